uart_alu_interface: RTL and testbench

Byte-level command processor between the UART receiver and transmitter in the UART-ALU top. It consumes received bytes as operand A, operand B and opcode, in that order. It evaluates the operation in an internal ALU, hands the 8-bit result to the transmitter with a one-cycle start strobe, and waits for transmit completion before accepting the next command.

---
 rtl/uart_alu_interface_if.sv | 22 ++
 rtl/uart_alu_interface.sv | 97 +++++++++
 tb/tb_uart_alu_interface.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_alu_interface_if.sv
// Byte/result handshake between the UART datapath and the ALU command processor.
// master drives received bytes and tx completion; slave returns result and busy.
interface uart_alu_interface_if #(
   parameter int D_BIT = 8
);
   logic             i_rx_done;
   logic [D_BIT-1:0] i_rx_data;
   logic             i_tx_done;
   logic             o_tx_start;
   logic [D_BIT-1:0] o_tx_data;
   logic             o_busy;

   modport master (
      output i_rx_done, i_rx_data, i_tx_done,
      input  o_tx_start, o_tx_data, o_busy
   );

   modport slave (
      input  i_rx_done, i_rx_data, i_tx_done,
      output o_tx_start, o_tx_data, o_busy
   );
endinterface

// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode bytes from the UART receiver, evaluates
// them in a combinational ALU and hands the result to the transmitter.
module uart_alu_interface #(
   parameter int D_BIT  = 8,
   parameter int OP_BIT = 6
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   uart_alu_interface_if.slave  bus
);

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      SEND    = 3'd3,
      WAIT_TX = 3'd4
   } state_t;

   localparam logic [OP_BIT-1:0] OP_ADD = OP_BIT'(6'b100000);
   localparam logic [OP_BIT-1:0] OP_SUB = OP_BIT'(6'b100010);
   localparam logic [OP_BIT-1:0] OP_AND = OP_BIT'(6'b100100);
   localparam logic [OP_BIT-1:0] OP_OR  = OP_BIT'(6'b100101);
   localparam logic [OP_BIT-1:0] OP_XOR = OP_BIT'(6'b100110);
   localparam logic [OP_BIT-1:0] OP_NOR = OP_BIT'(6'b100111);
   localparam logic [OP_BIT-1:0] OP_SRA = OP_BIT'(6'b000011);
   localparam logic [OP_BIT-1:0] OP_SRL = OP_BIT'(6'b000010);

   state_t              r_state, w_state_nxt;
   logic [D_BIT-1:0]    r_a, r_b, r_tx_data;
   logic [OP_BIT-1:0]   r_op, w_op;
   logic [D_BIT-1:0]    w_alu;
   logic                w_ld_a, w_ld_b, w_ld_op;
   logic                w_shift_ovf;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= WAIT_A;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ld_a      = 1'b0;
      w_ld_b      = 1'b0;
      w_ld_op     = 1'b0;
      case (r_state)
         WAIT_A:  if (bus.i_rx_done) begin w_ld_a  = 1'b1; w_state_nxt = WAIT_B;  end
         WAIT_B:  if (bus.i_rx_done) begin w_ld_b  = 1'b1; w_state_nxt = WAIT_OP; end
         WAIT_OP: if (bus.i_rx_done) begin w_ld_op = 1'b1; w_state_nxt = SEND;    end
         SEND:    w_state_nxt = WAIT_TX;
         WAIT_TX: if (bus.i_tx_done) w_state_nxt = WAIT_A;
         default: w_state_nxt = WAIT_A;
      endcase
   end

   // ALU sees the opcode byte in the cycle it arrives so the result can be
   // registered on the same edge and be valid during SEND.
   assign w_op        = w_ld_op ? bus.i_rx_data[OP_BIT-1:0] : r_op;
   assign w_shift_ovf = (32'(r_b) >= D_BIT);

   always_comb begin
      w_alu = '0;
      case (w_op)
         OP_ADD: w_alu = r_a + r_b;
         OP_SUB: w_alu = r_a - r_b;
         OP_AND: w_alu = r_a & r_b;
         OP_OR:  w_alu = r_a | r_b;
         OP_XOR: w_alu = r_a ^ r_b;
         OP_NOR: w_alu = ~(r_a | r_b);
         OP_SRA: w_alu = w_shift_ovf ? {D_BIT{r_a[D_BIT-1]}}
                                     : D_BIT'($signed(r_a) >>> r_b);
         OP_SRL: w_alu = w_shift_ovf ? '0 : (r_a >> r_b);
         default: w_alu = '0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= '0;
         r_tx_data <= '0;
      end else begin
         if (w_ld_a)  r_a <= bus.i_rx_data;
         if (w_ld_b)  r_b <= bus.i_rx_data;
         if (w_ld_op) begin
            r_op      <= bus.i_rx_data[OP_BIT-1:0];
            r_tx_data <= w_alu;
         end
      end
   end

   assign bus.o_tx_start = (r_state == SEND);
   assign bus.o_tx_data  = r_tx_data;
   assign bus.o_busy     = (r_state == SEND) || (r_state == WAIT_TX);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface: inputs driven on falling edges,
// outputs sampled on the following falling edge.
module tb_uart_alu_interface;

   logic i_clk;
   logic i_reset;
   int   checks   = 0;
   int   failures = 0;

   uart_alu_interface_if #(.D_BIT(8)) bus ();

   uart_alu_interface #(.D_BIT(8), .OP_BIT(6)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus.slave)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.i_rx_done = 1'b1;
      bus.i_rx_data = b;
      @(negedge i_clk);
      bus.i_rx_done = 1'b0;
      bus.i_rx_data = 8'h00;
   endtask

   // Sends a full command; on return we are inside the SEND cycle.
   task automatic send_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp);
      send_byte(a);
      send_byte(b);
      check({tag, " busy_before_op"}, {7'b0, bus.o_busy}, 8'h00);
      send_byte(op);
      check({tag, " start"}, {7'b0, bus.o_tx_start}, 8'h01);
      check({tag, " data"},  bus.o_tx_data, exp);
      check({tag, " busy"},  {7'b0, bus.o_busy}, 8'h01);
   endtask

   task automatic finish_tx(input string tag, input logic [7:0] exp);
      bus.i_tx_done = 1'b1;
      @(negedge i_clk);
      bus.i_tx_done = 1'b0;
      check({tag, " idle_busy"}, {7'b0, bus.o_busy}, 8'h00);
      check({tag, " data_held"}, bus.o_tx_data, exp);
   endtask

   task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] exp);
      send_cmd(tag, a, b, op, exp);
      @(negedge i_clk);
      check({tag, " start_one_cycle"}, {7'b0, bus.o_tx_start}, 8'h00);
      check({tag, " busy_wait_tx"},    {7'b0, bus.o_busy}, 8'h01);
      finish_tx(tag, exp);
   endtask

   initial begin
      bus.i_rx_done = 1'b0;
      bus.i_rx_data = 8'h00;
      bus.i_tx_done = 1'b0;
      i_reset       = 1'b0;
      repeat (2) @(negedge i_clk);
      check("rst start",  {7'b0, bus.o_tx_start}, 8'h00);
      check("rst data",   bus.o_tx_data, 8'h00);
      check("rst busy",   {7'b0, bus.o_busy}, 8'h00);
      i_reset = 1'b1;
      @(negedge i_clk);

      // Abort a command after operand A, asynchronously
      send_byte(8'h11);
      check("mid_b r_a", dut.r_a, 8'h11);
      #2 i_reset = 1'b0;
      #1;
      check("async rst r_a",  dut.r_a, 8'h00);
      check("async rst busy", {7'b0, bus.o_busy}, 8'h00);
      check("async rst data", bus.o_tx_data, 8'h00);
      @(negedge i_clk);
      i_reset = 1'b1;
      @(negedge i_clk);
      run_cmd("add_after_rst", 8'h05, 8'h03, 8'h20, 8'h08);

      run_cmd("add_wrap", 8'hFF, 8'h01, 8'h20, 8'h00);
      run_cmd("sub_wrap", 8'h00, 8'h01, 8'h22, 8'hFF);
      run_cmd("and",      8'hF0, 8'h3C, 8'h24, 8'h30);
      run_cmd("xor",      8'hF0, 8'h3C, 8'h26, 8'hCC);
      run_cmd("nor",      8'hF0, 8'h3C, 8'h27, 8'h03);
      run_cmd("sra3",     8'h80, 8'h03, 8'h03, 8'hF0);
      run_cmd("srl3",     8'h80, 8'h03, 8'h02, 8'h10);
      run_cmd("sra9",     8'h80, 8'h09, 8'h03, 8'hFF);
      run_cmd("srl9",     8'h80, 8'h09, 8'h02, 8'h00);
      run_cmd("or",       8'h0A, 8'h50, 8'h25, 8'h5A);
      run_cmd("invalid",  8'h12, 8'h34, 8'h3F, 8'h00);
      // Upper bits of the opcode byte are ignored: 0xE0 -> ADD
      run_cmd("op_mask",  8'h10, 8'h22, 8'hE0, 8'h32);

      // Bytes arriving while busy are dropped
      send_cmd("busy_drop", 8'h0F, 8'h01, 8'h20, 8'h10);
      @(negedge i_clk);
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'h20);
      check("busy_drop no_start", {7'b0, bus.o_tx_start}, 8'h00);
      check("busy_drop busy",     {7'b0, bus.o_busy}, 8'h01);
      check("busy_drop data",     bus.o_tx_data, 8'h10);
      check("busy_drop r_a",      dut.r_a, 8'h0F);
      finish_tx("busy_drop", 8'h10);
      run_cmd("after_drop", 8'h01, 8'h01, 8'h25, 8'h01);

      // tx_done outside WAIT_TX is ignored
      bus.i_tx_done = 1'b1;
      @(negedge i_clk);
      bus.i_tx_done = 1'b0;
      check("stray_tx_done busy", {7'b0, bus.o_busy}, 8'h00);

      // rx_done and tx_done together in WAIT_TX: byte dropped
      send_cmd("simul", 8'h04, 8'h04, 8'h25, 8'h04);
      @(negedge i_clk);
      bus.i_rx_done = 1'b1;
      bus.i_rx_data = 8'h77;
      bus.i_tx_done = 1'b1;
      @(negedge i_clk);
      bus.i_rx_done = 1'b0;
      bus.i_rx_data = 8'h00;
      bus.i_tx_done = 1'b0;
      check("simul busy", {7'b0, bus.o_busy}, 8'h00);
      check("simul r_a",  dut.r_a, 8'h04);
      run_cmd("simul_next", 8'h02, 8'h03, 8'h20, 8'h05);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
